prog_loader_ctrl: RTL and testbench
===================================

# prog_loader_ctrl

Sequencer that fills instruction memory from a byte stream and then releases the core. It receives a framed program over an 8-bit valid/ready link: length header, little-endian instruction words, XOR checksum. It drives the instruction-memory debug write port (DEBUG_SIG / DEBUG_addr / DEBUG_instr plus a write strobe) and asserts START only after a frame is fully written and verified. It sits between the host link (UART/JTAG bridge) and the instruction memory, and replaces fixed-table program loading.

## Interface
- MAX_WORDS, 1024, maximum accepted program length in 32-bit words (must be ≤ 65535)
- BASE_ADDR, 0, word address written for program word 0

Ports:
- clk  in  1  system clock; all logic on rising edge
- nrst  in  1  reset, synchronous, active-low
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  controller accepts byte this cycle
- load_req  in  1  single-cycle pulse: abort/restart, wait for new frame
- DEBUG_SIG  out  1  core held and imem port owned by loader
- DEBUG_addr  out  32  imem word address
- DEBUG_instr  out  32  imem write data
- DEBUG_we  out  1  one-cycle imem write strobe
- START  out  1  core run enable (level)
- err  out  1  frame rejected (level)
- words_loaded  out  16  words written in the current frame

## Operation
- Byte accepted iff rx_valid & rx_ready. rx_ready = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in RUN and ERR.
- States: LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR. After reset: LEN_LO.
- LEN_LO: accepted byte becomes len[7:0]. Go to LEN_HI.
- LEN_HI: accepted byte becomes len[15:8]. If len==0 or len>MAX_WORDS, go to ERR. Otherwise go to DATA with byte_idx=0, word_idx=0, csum=0.
- DATA: bytes are little-endian, so byte 0 is instr[7:0]. Every accepted byte is XORed into csum.
  - On the 4th byte of a word, the next cycle presents DEBUG_instr = assembled word, DEBUG_addr = BASE_ADDR + word_idx, DEBUG_we = 1 for exactly one cycle. words_loaded increments in the same cycle.
  - After word len-1 is accepted, go to CSUM.
- CSUM: accepted byte is compared with csum. Equal: go to RUN. Different: go to ERR.
- RUN: START=1, DEBUG_SIG=0. Ignores rx.
- ERR: err=1, START=0, DEBUG_SIG=1. Words already written stay in imem and are not rolled back.
- load_req in any state goes to LEN_LO next cycle. It clears err, csum, counters and words_loaded, sets START=0 and DEBUG_SIG=1. A pending partial word is dropped.
- load_req has priority over a byte accept in the same cycle. That byte is consumed (rx_ready was 1) and discarded.
- Length and index arithmetic is 16-bit unsigned. Address is 32-bit: zero-extended word_idx plus BASE_ADDR, modulo 2^32.

## Timing
- Reset values: rx_ready=1, DEBUG_SIG=1, DEBUG_addr=BASE_ADDR, DEBUG_instr=0, DEBUG_we=0, START=0, err=0, words_loaded=0.
- All outputs are registered.
- rx_ready is a registered function of state. It is valid in the cycle after the state transition.
- Write latency is 1 cycle from acceptance of a word's last byte to DEBUG_we. DEBUG_addr and DEBUG_instr are stable while DEBUG_we=1 and hold their values afterward.
- The checksum byte is accepted in cycle N. In cycle N+1, START=1, DEBUG_SIG=0, or err=1 on mismatch.
- Back-to-back bytes, one per cycle, are supported without stalls. Gaps in rx_valid of any length are tolerated.
- DEBUG_SIG and START are never both 1.
- START falls in the cycle after load_req.
- Reset mid-frame: outputs take their reset values on the next clk edge, and the partial frame is discarded.

## Test plan
- Good frame, 1 byte/cycle: 02 00 93 07 70 00 13 00 00 00 F7. Expect DEBUG_we at addr 0 with 0x00700793, then addr 1 with 0x00000013. Then START=1, DEBUG_SIG=0, words_loaded=2, err=0.
- Same frame with random rx_valid gaps (0–5 cycles): identical writes and final state. No DEBUG_we while a word is incomplete.
- Bad checksum (last byte 00 instead of F7): both words written, then err=1, START=0, rx_ready=0. A following load_req clears err and returns rx_ready=1.
- Length 00 00, and length MAX_WORDS+1: ERR right after the 2nd header byte, no DEBUG_we.
- load_req in RUN, and load_req coincident with the 3rd data byte: START drops or the frame aborts. words_loaded=0. A new good frame then loads correctly from addr BASE_ADDR.
- nrst low for 1 cycle after 5 data bytes: all outputs at reset values. A subsequent full frame loads and starts normally.

Source files
------------

// File: rtl/prog_loader_if.sv
// Host byte link and imem debug-write bundle for the program loader.
// master = host/stream side, slave = loader side.
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        load_req;
    logic        DEBUG_SIG;
    logic [31:0] DEBUG_addr;
    logic [31:0] DEBUG_instr;
    logic        DEBUG_we;
    logic        START;
    logic        err;
    logic [15:0] words_loaded;

    modport master (
        output rx_valid, rx_data, load_req,
        input  rx_ready, DEBUG_SIG, DEBUG_addr, DEBUG_instr,
        input  DEBUG_we, START, err, words_loaded
    );

    modport slave (
        input  rx_valid, rx_data, load_req,
        output rx_ready, DEBUG_SIG, DEBUG_addr, DEBUG_instr,
        output DEBUG_we, START, err, words_loaded
    );
endinterface

// File: rtl/prog_loader_ctrl.sv
// Framed program loader: length, LE words, XOR checksum -> imem writes,
// then releases the core with START.
module prog_loader_ctrl #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input logic          clk,
    input logic          nrst,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {
        LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR
    } state_t;

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] buf_q, buf_d;
    logic        rx_ready_q, rx_ready_d;
    logic        dbg_sig_q, dbg_sig_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        we_q, we_d;
    logic        start_q, start_d;
    logic        err_q, err_d;
    logic [15:0] words_q, words_d;
    logic        accept;
    logic [15:0] new_len;

    assign accept = bus.rx_valid & rx_ready_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        we_d       = 1'b0;
        words_d    = words_q;
        new_len    = {bus.rx_data, len_q[7:0]};

        // Restart wins over any byte accepted in the same cycle
        if (bus.load_req) begin
            state_d    = LEN_LO;
            byte_idx_d = 2'd0;
            word_idx_d = 16'd0;
            csum_d     = 8'd0;
            words_d    = 16'd0;
        end else if (accept) begin
            unique case (state_q)
                LEN_LO: begin
                    len_d   = {len_q[15:8], bus.rx_data};
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    len_d      = new_len;
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                    csum_d     = 8'd0;
                    if (new_len == 16'd0 || new_len > MAX_W)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
                DATA: begin
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: buf_d[7:0]   = bus.rx_data;
                        2'd1: buf_d[15:8]  = bus.rx_data;
                        2'd2: buf_d[23:16] = bus.rx_data;
                        2'd3: begin
                            instr_d    = {bus.rx_data, buf_q};
                            addr_d     = BASE_ADDR + {16'd0, word_idx_q};
                            we_d       = 1'b1;
                            words_d    = words_q + 16'd1;
                            word_idx_d = word_idx_q + 16'd1;
                            if (word_idx_q == len_q - 16'd1)
                                state_d = CSUM;
                        end
                    endcase
                end
                CSUM: begin
                    state_d = (bus.rx_data == csum_q) ? RUN : ERR;
                end
                RUN, ERR: begin
                end
                default: state_d = LEN_LO;
            endcase
        end

        rx_ready_d = (state_d != RUN) && (state_d != ERR);
        dbg_sig_d  = (state_d != RUN);
        start_d    = (state_d == RUN);
        err_d      = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= LEN_LO;
            len_q      <= 16'd0;
            byte_idx_q <= 2'd0;
            word_idx_q <= 16'd0;
            csum_q     <= 8'd0;
            buf_q      <= 24'd0;
            rx_ready_q <= 1'b1;
            dbg_sig_q  <= 1'b1;
            addr_q     <= BASE_ADDR;
            instr_q    <= 32'd0;
            we_q       <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            buf_q      <= buf_d;
            rx_ready_q <= rx_ready_d;
            dbg_sig_q  <= dbg_sig_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            we_q       <= we_d;
            start_q    <= start_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.DEBUG_SIG    = dbg_sig_q;
    assign bus.DEBUG_addr   = addr_q;
    assign bus.DEBUG_instr  = instr_q;
    assign bus.DEBUG_we     = we_q;
    assign bus.START        = start_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Scoreboard bench for prog_loader_ctrl: expected imem writes queued by
// stimulus, popped by a monitor on every DEBUG_we.
module tb_prog_loader_ctrl;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] exp_q[$];

    prog_loader_if bus();

    prog_loader_ctrl #(.MAX_WORDS(1024), .BASE_ADDR(32'd0)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            checks++;
            if (bus.DEBUG_SIG && bus.START) begin
                errors++;
                $display("FAIL sig_start_excl: both high");
            end
        end
        if (bus.DEBUG_we === 1'b1) begin
            logic [63:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: addr %h instr %h",
                         bus.DEBUG_addr, bus.DEBUG_instr);
            end else begin
                e = exp_q.pop_front();
                if ({bus.DEBUG_addr, bus.DEBUG_instr} !== e) begin
                    errors++;
                    $display("FAIL imem_write: got %h/%h expected %h/%h",
                             bus.DEBUG_addr, bus.DEBUG_instr,
                             e[63:32], e[31:0]);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            acc = bus.rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.rx_valid = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: byte %h not accepted", b);
        end
    endtask

    task automatic send_good(input logic [7:0] last, input bit gaps);
        logic [7:0] f [11];
        f = '{8'h02, 8'h00, 8'h93, 8'h07, 8'h70, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'hF7};
        f[10] = last;
        exp_q.push_back({32'd0, 32'h0070_0793});
        exp_q.push_back({32'd1, 32'h0000_0013});
        for (int i = 0; i < 11; i++)
            send_byte(f[i], gaps ? int'($urandom_range(0, 5)) : 0);
    endtask

    task automatic pulse_load;
        bus.load_req = 1'b1;
        @(posedge clk);
        #1;
        bus.load_req = 1'b0;
        chk("ld_start", {31'd0, bus.START}, 32'd0);
        chk("ld_sig", {31'd0, bus.DEBUG_SIG}, 32'd1);
        chk("ld_err", {31'd0, bus.err}, 32'd0);
        chk("ld_words", {16'd0, bus.words_loaded}, 32'd0);
        chk("ld_ready", {31'd0, bus.rx_ready}, 32'd1);
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_start"}, {31'd0, bus.START}, 32'd1);
        chk({tag, "_sig"}, {31'd0, bus.DEBUG_SIG}, 32'd0);
        chk({tag, "_words"}, {16'd0, bus.words_loaded}, 32'd2);
        chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
        chk({tag, "_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.rx_ready}, 32'd1);
        chk({tag, "_sig"}, {31'd0, bus.DEBUG_SIG}, 32'd1);
        chk({tag, "_addr"}, bus.DEBUG_addr, 32'd0);
        chk({tag, "_instr"}, bus.DEBUG_instr, 32'd0);
        chk({tag, "_we"}, {31'd0, bus.DEBUG_we}, 32'd0);
        chk({tag, "_start"}, {31'd0, bus.START}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
        chk({tag, "_words"}, {16'd0, bus.words_loaded}, 32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.load_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        nrst = 1'b1;

        send_good(8'hF7, 1'b0);
        chk_run("good");
        pulse_load();

        send_good(8'hF7, 1'b1);
        chk_run("gaps");
        pulse_load();

        send_good(8'h00, 1'b0);
        chk("bad_err", {31'd0, bus.err}, 32'd1);
        chk("bad_start", {31'd0, bus.START}, 32'd0);
        chk("bad_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("bad_sig", {31'd0, bus.DEBUG_SIG}, 32'd1);
        pulse_load();

        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("len0_err", {31'd0, bus.err}, 32'd1);
        chk("len0_words", {16'd0, bus.words_loaded}, 32'd0);
        pulse_load();

        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        chk("lenmax_err", {31'd0, bus.err}, 32'd1);
        chk("lenmax_ready", {31'd0, bus.rx_ready}, 32'd0);
        pulse_load();

        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        chk("lenok_err", {31'd0, bus.err}, 32'd0);
        pulse_load();

        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h07, 0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h70;
        pulse_load();
        bus.rx_valid = 1'b0;
        send_good(8'hF7, 1'b0);
        chk_run("after_abort");
        pulse_load();

        exp_q.push_back({32'd0, 32'h0070_0793});
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h07, 0);
        send_byte(8'h70, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        chk("mid_words", {16'd0, bus.words_loaded}, 32'd1);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("midrst");
        nrst = 1'b1;
        send_good(8'hF7, 1'b1);
        chk_run("after_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
